// File: rtl/serializer_pkg.sv
// Shared constants for the bit serializer:
// state encodings and the default word width.
package serializer_pkg;

   localparam int DEF_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      FULL  = 2'b10
   } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register
// so that back-to-back words stream out with no gap cycle.
module bit_serializer
   import serializer_pkg::*;
#(
   parameter int W         = DEF_W,
   parameter int MSB_FIRST = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         x,
   output logic         x_valid,
   output logic         busy
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t         state;
   state_t         state_n;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_n;
   logic [W-1:0]   sreg;
   logic [W-1:0]   sreg_n;
   logic [W-1:0]   hold;
   logic [W-1:0]   hold_n;
   logic [W-1:0]   shifted;
   logic           xfer;
   logic           last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         sreg  <= '0;
         hold  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         sreg  <= sreg_n;
         hold  <= hold_n;
      end
   end

   // Ready comes only from registered state.
   assign in_ready = (state == IDLE) || (state == SHIFT);
   assign busy     = (state != IDLE);
   assign x_valid  = busy;
   assign x        = busy & ((MSB_FIRST != 0) ? sreg[W-1] : sreg[0]);

   assign xfer    = in_valid & in_ready;
   assign last    = (cnt == LAST);
   assign shifted = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);

   always_comb begin
      state_n = IDLE;
      cnt_n   = cnt;
      sreg_n  = sreg;
      hold_n  = hold;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (xfer) begin
               sreg_n  = in_data;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (last) begin
               cnt_n = '0;
               // Bypass: a word arriving on the last bit goes
               // straight to the shifter.
               if (xfer) begin
                  sreg_n  = in_data;
                  state_n = SHIFT;
               end else begin
                  sreg_n  = '0;
                  state_n = IDLE;
               end
            end else begin
               cnt_n  = cnt + 1'b1;
               sreg_n = shifted;
               if (xfer) begin
                  hold_n  = in_data;
                  state_n = FULL;
               end else begin
                  state_n = SHIFT;
               end
            end
         end
         FULL: begin
            if (last) begin
               cnt_n   = '0;
               sreg_n  = hold;
               hold_n  = '0;
               state_n = SHIFT;
            end else begin
               cnt_n   = cnt + 1'b1;
               sreg_n  = shifted;
               state_n = FULL;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            sreg_n  = '0;
            hold_n  = '0;
         end
      endcase
   end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the parallel word width in bits (W >= 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit W-1 first, 0 = bit 0 first.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port in_data, input, W: parallel word to serialize.
REQ-006 Port in_valid, input, 1: in_data holds a word.
REQ-007 Port in_ready, output, 1: block can accept a word this cycle.
REQ-008 Port x, output, 1: serial bit stream for the downstream sequence detector.
REQ-009 Port x_valid, output, 1: x carries a data bit this cycle.
REQ-010 Port busy, output, 1: a word is being shifted or is held.

Function
REQ-011 A word SHALL transfer only when in_valid and in_ready are both 1 at a rising clk edge.
REQ-012 The block SHALL implement three states: IDLE (shifter empty), SHIFT (shifter loaded, holding register empty), FULL (shifter loaded, holding register occupied).
REQ-013 in_ready SHALL be 1 in IDLE and SHIFT and 0 in FULL, decoded from registered state only, with no combinational path from in_valid.
REQ-014 IDLE with transfer: the word SHALL load into the shifter, bit counter = 0, next state SHIFT.
REQ-015 The first bit of an accepted word SHALL appear on x, with x_valid = 1, in the cycle after the accepting edge (latency 1).
REQ-016 In SHIFT or FULL, each edge SHALL advance one bit, and the counter SHALL increment 0..W-1.
REQ-017 Bit order SHALL be set by MSB_FIRST.
REQ-018 SHIFT, counter < W-1, with transfer: the word SHALL go to the holding register, next state FULL.
REQ-019 SHIFT, counter = W-1, with transfer: the word SHALL load directly into the shifter, bypassing the holding register, counter = 0, state stays SHIFT, leaving no gap cycle.
REQ-020 SHIFT, counter = W-1, no transfer: next state IDLE.
REQ-021 FULL, counter = W-1: the holding word SHALL move to the shifter, counter = 0, next state SHIFT, leaving no gap cycle.
REQ-022 In IDLE, x SHALL be 0 and x_valid SHALL be 0, so that an idle line resets the downstream pattern search.
REQ-023 busy SHALL be 1 exactly when state is not IDLE.
REQ-024 Words SHALL never be dropped, duplicated or reordered.
REQ-025 in_data SHALL be ignored when no transfer occurs.
REQ-026 Illegal state encodings SHALL return the block to IDLE on the next edge.

Reset
REQ-027 On rst low, asynchronously: state = IDLE, counter = 0, shifter = 0, holding register = 0, x = 0, x_valid = 0, busy = 0, in_ready = 1.
REQ-028 Reset mid-word SHALL discard the partial word and any held word.
REQ-029 The first edge after rst rises SHALL be able to accept a word.

Structure
REQ-030 The state encoding constants (IDLE, SHIFT, FULL) and the default W SHALL live in a shared package serializer_pkg.
REQ-031 The block SHALL be a single module, with no sub-module; the counter is width $clog2(W), wide enough to hold W-1.

Verification
REQ-032 Scenario: W=8, MSB_FIRST=1, one word 0xDB accepted -> x = 1,1,0,1,1,0,1,1 on 8 consecutive cycles with x_valid = 1, then x = 0, x_valid = 0, busy = 0.
REQ-033 Scenario: 0xDB then 0x6C offered back-to-back with in_valid held high -> 16 contiguous valid bits 11011011 01101100; in_ready = 0 from the edge 0x6C is held until it moves to the shifter.
REQ-034 Scenario: a third word is offered while in FULL -> it is not accepted until in_ready returns to 1, and is then shifted intact after the second word.
REQ-035 Scenario: rst pulsed low after the 3rd bit of 0xFF -> x = 0, x_valid = 0, in_ready = 1 immediately; a new word 0x0F afterwards serializes as 0,0,0,0,1,1,1,1.
REQ-036 Scenario: MSB_FIRST=0, word 0x36 -> x = 0,1,1,0,1,1,0,0.
REQ-037 Scenario: the bypass case, a transfer exactly at counter = W-1 in SHIFT -> no idle cycle between words and state remains SHIFT.
